hs_receiver: RTL and testbench

- Downstream consumer for the memory-backed sender; sits directly on its valid/ready/data interface.
- Paces ready with a programmable idle gap, captures DEPTH words into a local memory, and keeps a running count and a checksum.
- After DEPTH words it raises done and stops accepting.
- A registered readback port lets the bench and downstream logic inspect captured words.

---
 rtl/hs_pkg.sv | 24 ++
 rtl/hs_gap_timer.sv | 37 +++
 rtl/hs_receiver.sv | 107 ++++++++++
 tb/tb_hs_receiver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready sender/receiver pair: FSM state encoding and width helpers.
package hs_pkg;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_RDY  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    WAIT = ST_WAIT,
    RDY  = ST_RDY,
    DONE = ST_DONE
  } hs_state_t;

  // Counter able to hold 0..depth inclusive.
  function automatic int hs_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Address into a depth-entry memory, never narrower than one bit.
  function automatic int hs_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hs_gap_timer.sv
// Idle-gap timer: a one-cycle start arms it, expired pulses in the last cycle of a GAP-cycle wait.
// GAP=0 has no wait, so expired simply follows start.
module hs_gap_timer #(
  parameter int GAP = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int            TW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] LAST = (GAP > 0) ? TW'(GAP - 1) : '0;

  logic [TW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= (GAP > 0);
    end else if (run) begin
      if (cnt == LAST) begin
        cnt <= '0;
        run <= 1'b0;
      end else begin
        cnt <= cnt + TW'(1);
      end
    end
  end

  assign expired = (GAP == 0) ? start : (run && (cnt == LAST));

endmodule

// File: rtl/hs_receiver.sv
// Valid/ready sink: paces a registered ready with a GAP-cycle idle gap, captures DEPTH words, sums them.
// ready rises GAP+1 edges after reset and GAP edges after each transfer; after DEPTH words done holds intake off.
module hs_receiver
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int GAP        = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic                        ready,
  output logic [hs_cnt_w(DEPTH)-1:0]  count,
  output logic                        done,
  output logic [DATA_WIDTH-1:0]       checksum,
  input  logic [hs_addr_w(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int CW = hs_cnt_w(DEPTH);
  localparam int AW = hs_addr_w(DEPTH);

  hs_state_t             state;
  logic                  arm;
  logic                  fire;
  logic                  last;
  logic                  start;
  logic                  expired;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign fire = valid && ready;
  assign last = (count == CW'(DEPTH - 1));

  // arm kicks the timer on the first edge out of reset, which is why that wait is one edge longer.
  assign start = arm || (fire && !last && (GAP != 0));

  hs_gap_timer #(
    .GAP(GAP)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= WAIT;
      ready    <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      checksum <= '0;
      arm      <= 1'b1;
    end else begin
      arm <= 1'b0;
      case (state)
        WAIT: begin
          if (expired) begin
            state <= RDY;
            ready <= 1'b1;
          end
        end
        RDY: begin
          if (fire) begin
            count    <= count + CW'(1);
            checksum <= checksum + data;
            if (last) begin
              state <= DONE;
              ready <= 1'b0;
              done  <= 1'b1;
            end else if (GAP == 0) begin
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              ready <= 1'b0;
            end
          end
        end
        DONE: begin
          ready <= 1'b0;
        end
        default: begin
          state <= WAIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Capture memory has no reset; a new run simply overwrites from address 0.
  always_ff @(posedge clk) begin
    if (rst && fire) begin
      mem[count[AW-1:0]] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_hs_receiver.sv
// Scoreboard bench for hs_receiver: one instance with a 10-cycle gap, one with no gap,
// each shadowed by a behavioural model of count, checksum, done, ready and readback.
module tb_hs_receiver;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int NG    = 2;
  localparam int GAP_A = 10;
  localparam int GAP_B = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid    [NG];
  logic [DW-1:0] data     [NG];
  logic [AW-1:0] rd_addr  [NG];
  logic          ready    [NG];
  logic [CW-1:0] count    [NG];
  logic          done     [NG];
  logic [DW-1:0] checksum [NG];
  logic [DW-1:0] rd_data  [NG];

  int          checks  = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  bit          rd_rand = 1'b1;
  logic [DW-1:0] exp_q [NG][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hs_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(GAP_A)) u_dut_gap (
    .clk(clk), .rst(rst), .valid(valid[0]), .data(data[0]), .ready(ready[0]),
    .count(count[0]), .done(done[0]), .checksum(checksum[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0])
  );

  hs_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(GAP_B)) u_dut_nogap (
    .clk(clk), .rst(rst), .valid(valid[1]), .data(data[1]), .ready(ready[1]),
    .count(count[1]), .done(done[1]), .checksum(checksum[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1])
  );

  task automatic check(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, g, got, exp);
    end
  endtask

  // Reference model: ready is owed once the required number of idle edges has elapsed
  // since reset release or the previous transfer; every transfer consumes the oldest offered word.
  for (genvar g = 0; g < NG; g++) begin : g_mon
    localparam int MG = (g == 0) ? GAP_A : GAP_B;
    bit            started  = 1'b0;
    bit            rexp_vld = 1'b0;
    bit            er;
    int            mcnt     = 0;
    int            mwait    = 0;
    logic [DW-1:0] msum     = '0;
    logic [DW-1:0] rexp     = '0;
    logic [DW-1:0] mword;
    logic [DW-1:0] mmem [DEPTH];
    bit            mvld [DEPTH];

    always @(negedge clk) begin
      er = (mcnt < DEPTH) && (mwait == 0);
      if (started) begin
        check("count", g, 32'(count[g]), 32'(mcnt));
        check("checksum", g, 32'(checksum[g]), 32'(msum));
        check("done", g, 32'(done[g]), 32'(mcnt == DEPTH));
        check("ready", g, 32'(ready[g]), 32'(er));
        if (rexp_vld) check("rd_data", g, 32'(rd_data[g]), 32'(rexp));
      end
      if (rst === 1'b0) begin
        started  = 1'b1;
        mcnt     = 0;
        msum     = '0;
        mwait    = MG + 1;
        rexp_vld = 1'b1;
        rexp     = '0;
        exp_q[g].delete();
      end else if (started) begin
        rexp_vld = mvld[rd_addr[g]];
        rexp     = mmem[rd_addr[g]];
        if (valid[g] && er) begin
          if (exp_q[g].size() == 0) begin
            check("xfer_without_offer", g, 32'(valid[g]), 32'd0);
            mword = data[g];
          end else begin
            mword = exp_q[g].pop_front();
          end
          mmem[mcnt] = mword;
          mvld[mcnt] = 1'b1;
          mcnt       = mcnt + 1;
          msum       = msum + mword;
          mwait      = MG;
        end else if (mwait > 0) begin
          mwait = mwait - 1;
        end
      end
    end
  end

  // Offers one word. Held mode keeps valid/data stable through the gap; junk mode
  // scribbles random valid/data while ready is low and presents the real word only once ready is seen.
  task automatic send(input int g, input logic [DW-1:0] w, input bit junk);
    int guard = 0;
    if (!junk) begin
      valid[g] = 1'b1;
      data[g]  = w;
      exp_q[g].push_back(w);
    end
    while (ready[g] !== 1'b1) begin
      if (junk) begin
        valid[g] = 1'($urandom_range(0, 1));
        data[g]  = DW'($urandom);
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout[%0d] got ready=%0b expected 1 within 100 cycles", g, ready[g]);
        valid[g] = 1'b0;
        return;
      end
    end
    if (junk) begin
      valid[g] = 1'b1;
      data[g]  = w;
      exp_q[g].push_back(w);
    end
    @(posedge clk); #1;
    valid[g] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rd_rand) begin
        for (int k = 0; k < NG; k++) rd_addr[k] = AW'($urandom);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            n;
    int            n1;
    int unsigned   t0;
    int unsigned   s;
    logic [DW-1:0] w0 [DEPTH];

    rst = 1'b0;
    for (int k = 0; k < NG; k++) begin
      valid[k]   = 1'b0;
      data[k]    = '0;
      rd_addr[k] = '0;
    end

    // Reset, then idle: ready rise latency for both gap settings.
    do_reset(3);
    n  = 0;
    n1 = 0;
    while (ready[0] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (ready[1] === 1'b1 && n1 == 0) n1 = n;
    end
    check("rise_edges_gap10", 0, 32'(n), 32'd11);
    check("rise_edges_gap0", 1, 32'(n1), 32'd1);
    check("idle_count", 0, 32'(count[0]), 32'd0);
    check("idle_done", 0, 32'(done[0]), 32'd0);

    // Stream 0x00..0x0F with valid held through each gap.
    for (int i = 0; i < DEPTH; i++) send(0, DW'(i), 1'b0);
    check("run1_done", 0, 32'(done[0]), 32'd1);
    check("run1_count", 0, 32'(count[0]), 32'd16);
    check("run1_checksum", 0, 32'(checksum[0]), 32'h78);
    repeat (3) @(posedge clk);
    #1;
    check("run1_ready_after_done", 0, 32'(ready[0]), 32'd0);

    rd_rand = 1'b0;
    rd_addr[0] = AW'(5);
    @(posedge clk); #1;
    check("readback_5", 0, 32'(rd_data[0]), 32'h05);
    rd_addr[0] = AW'(15);
    @(posedge clk); #1;
    check("readback_15", 0, 32'(rd_data[0]), 32'h0F);
    rd_rand = 1'b1;

    // No gap: sixteen 0xFF words back-to-back.
    t0 = cyc;
    for (int i = 0; i < DEPTH; i++) send(1, 8'hFF, 1'b0);
    check("nogap_edges", 1, 32'(cyc - t0), 32'd16);
    check("nogap_done", 1, 32'(done[1]), 32'd1);
    check("nogap_checksum", 1, 32'(checksum[1]), 32'hF0);
    check("nogap_count", 1, 32'(count[1]), 32'd16);

    // Random words with junk on the bus while ready is low.
    do_reset(2);
    s = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w0[i] = DW'($urandom);
      s     = s + w0[i];
      send(0, w0[i], 1'b1);
    end
    check("junk_checksum", 0, 32'(checksum[0]), s % 256);
    check("junk_done", 0, 32'(done[0]), 32'd1);
    rd_rand = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr[0] = AW'(a);
      @(posedge clk); #1;
      check("junk_readback", 0, 32'(rd_data[0]), 32'(w0[a]));
    end
    rd_rand = 1'b1;
    s = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w0[i] = DW'($urandom);
      s     = s + w0[i];
      send(1, w0[i], 1'b1);
    end
    check("junk_nogap_checksum", 1, 32'(checksum[1]), s % 256);

    // Reset mid-run, on an edge where valid and ready are both high.
    do_reset(2);
    for (int i = 0; i < 7; i++) send(0, DW'($urandom), 1'b0);
    check("pre_reset_count", 0, 32'(count[0]), 32'd7);
    valid[0] = 1'b1;
    data[0]  = 8'hAA;
    n = 0;
    while (ready[0] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_reset", 0, 32'(ready[0]), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    check("reset_count", 0, 32'(count[0]), 32'd0);
    check("reset_checksum", 0, 32'(checksum[0]), 32'd0);
    check("reset_ready", 0, 32'(ready[0]), 32'd0);
    check("reset_done", 0, 32'(done[0]), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(0, DW'(8'h10 + i), 1'b0);
    check("rerun_checksum", 0, 32'(checksum[0]), 32'h78);
    check("rerun_done", 0, 32'(done[0]), 32'd1);
    check("rerun_count", 0, 32'(count[0]), 32'd16);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
